// File: rtl/hashcore_seq.sv
// Nonce sequencer and golden-nonce collector for NUM_CORES hash pipelines.
// Optional `HASHCORE_SEQ_MATCH_COUNT_EN adds a saturating accepted-match counter.
module hashcore_seq #(
    parameter int NUM_CORES    = 4,
    parameter int PIPE_LATENCY = 65,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   hash_clk,
    input  logic                   reset_n,
    input  logic                   restart,
    input  logic [NUM_CORES-1:0]   gn_match,
    output logic [32*NUM_CORES-1:0] nonce_bus,
    output logic [31:0]            gn_data,
    output logic                   gn_valid,
    input  logic                   gn_ready,
    output logic                   gn_overflow,
    output logic                   miner_busy
`ifdef HASHCORE_SEQ_MATCH_COUNT_EN
    ,
    output logic [15:0]            match_count
`endif
);

    localparam int P     = $clog2(NUM_CORES);
    localparam int CNT_W = 32 - P;
    localparam int SW    = (P > 0) ? P : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    // Core prefix sits above the shared counter; the shift vanishes when P is 0.
    function automatic logic [31:0] core_nonce(input logic [31:0] k, input logic [CNT_W-1:0] c);
        return (k << CNT_W) | 32'(c);
    endfunction

    function automatic logic [31:0] golden_nonce(input logic [31:0] k, input logic [CNT_W-1:0] c);
        return core_nonce(k, c) - 32'(PIPE_LATENCY);
    endfunction

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic [NUM_CORES-1:0] slot_vld_q, slot_vld_d;
    logic [31:0]          slot_val_q [NUM_CORES];
    logic [31:0]          slot_val_d [NUM_CORES];
    logic [31:0]          fifo_mem_q [FIFO_DEPTH];
    logic [31:0]          fifo_wdata_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [31:0]          gn_hold_q, gn_hold_d;

    logic [SW-1:0]        drain_sel;
    logic                 drain_any, fifo_full, push, pop, drop;
    logic [NUM_CORES-1:0] drain_clr, accept;

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            nonce_bus[32*k +: 32] = core_nonce(32'(k), cnt_q);
        end
    end

    assign gn_valid    = (fifo_cnt_q != '0);
    assign gn_data     = gn_valid ? fifo_mem_q[rd_ptr_q] : gn_hold_q;
    assign gn_overflow = overflow_q;
    assign miner_busy  = busy_q;

    // Drain arbitration: lowest-index valid slot wins the single FIFO write port.
    always_comb begin
        drain_sel = '0;
        drain_any = (slot_vld_q != '0);
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (slot_vld_q[k]) drain_sel = SW'(k);
        end
        fifo_full = (fifo_cnt_q == CW'(FIFO_DEPTH));
        pop       = gn_valid && gn_ready && !restart;
        push      = drain_any && (!fifo_full || (gn_valid && gn_ready)) && !restart;
        drain_clr = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            drain_clr[k] = push && (drain_sel == SW'(k));
        end
        fifo_wdata_d = slot_val_q[drain_sel];
    end

    always_comb begin
        accept = '0;
        drop   = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            accept[k]     = gn_match[k] && !restart && (!slot_vld_q[k] || drain_clr[k]);
            drop          = drop | (gn_match[k] && !restart && !accept[k]);
            slot_vld_d[k] = !restart && (accept[k] || (slot_vld_q[k] && !drain_clr[k]));
            slot_val_d[k] = accept[k] ? golden_nonce(32'(k), cnt_q) : slot_val_q[k];
        end
    end

    always_comb begin
        cnt_d      = restart ? '0 : cnt_q + CNT_W'(1);
        busy_d     = restart ? 1'b1 : ((cnt_q == '1) ? 1'b0 : busy_q);
        overflow_d = !restart && (overflow_q || drop);
        wr_ptr_d   = restart ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d   = restart ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
        fifo_cnt_d = fifo_cnt_q;
        if (restart) fifo_cnt_d = '0;
        else if (push && !pop) fifo_cnt_d = fifo_cnt_q + CW'(1);
        else if (pop && !push) fifo_cnt_d = fifo_cnt_q - CW'(1);
        // Last popped value stays visible on gn_data while the FIFO is empty.
        gn_hold_d  = restart ? 32'h0 : (pop ? fifo_mem_q[rd_ptr_q] : gn_hold_q);
    end

    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
            slot_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            gn_hold_q  <= 32'h0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            slot_vld_q <= slot_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            gn_hold_q  <= gn_hold_d;
        end
    end

    // Payload storage carries no reset; the valid bits and counters guard it.
    always_ff @(posedge hash_clk) begin
        slot_val_q <= slot_val_d;
        if (reset_n && push) fifo_mem_q[wr_ptr_q] <= fifo_wdata_d;
    end

`ifdef HASHCORE_SEQ_MATCH_COUNT_EN
    logic [15:0] match_count_q, match_count_d;
    logic [16:0] match_sum;

    always_comb begin
        match_sum = {1'b0, match_count_q};
        for (int k = 0; k < NUM_CORES; k++) begin
            match_sum = match_sum + 17'(accept[k]);
        end
        match_count_d = restart ? 16'h0 : (match_sum[16] ? 16'hFFFF : match_sum[15:0]);
    end

    always_ff @(posedge hash_clk) begin
        if (!reset_n) match_count_q <= 16'h0;
        else          match_count_q <= match_count_d;
    end

    assign match_count = match_count_q;
`endif

endmodule
